// File: rtl/vm_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// vm_dispense_ctrl
//
// Dispense stage of the vending machine. Takes one vend request (item code and
// change owed in dollars), runs the selected item motor until the slot sensor
// reports the drop, then pays the change out of the coin hopper as 50- and
// 10-dollar coins, one coin per acknowledge handshake. Completion or error is
// reported to the vending core with single-cycle pulses.
//
// Optional feature:
//   VM_DISP_WATCHDOG_EN - adds an 8-bit watchdog that runs while waiting for
//                         the motor (VEND) or the hopper (COIN_WAIT). When it
//                         reaches TIMEOUT the vend is aborted through ERR and
//                         any remaining change is dropped.
//
// Parameters:
//   CHG_W    width of the change amount in dollars
//   TIMEOUT  watchdog limit in cycles (only used with VM_DISP_WATCHDOG_EN)
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   req             vend request, sampled only while idle
//   item            item code (0 water, 1 black tea, 2 coke, 3 juice)
//   change_amt      change owed in dollars, sampled with req
//   motor_done      slot sensor, high once the item has dropped
//   hopper_ack      hopper released the last requested coin
//   hopper_empty50  50-dollar tube is empty
//   busy            high whenever not idle
//   motor_en        item motor drive
//   motor_id        latched item code
//   coin50          one-cycle 50-dollar coin request
//   coin10          one-cycle 10-dollar coin request
//   done            one-cycle completion pulse
//   err             one-cycle error pulse
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module vm_dispense_ctrl #(
    parameter int CHG_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [1:0]       item,
    input  logic [CHG_W-1:0] change_amt,
    input  logic             motor_done,
    input  logic             hopper_ack,
    input  logic             hopper_empty50,
    output logic             busy,
    output logic             motor_en,
    output logic [1:0]       motor_id,
    output logic             coin50,
    output logic             coin10,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_CHG_SEL,
        S_COIN_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CHG_W-1:0] COIN_TEN   = CHG_W'(10);
    localparam logic [CHG_W-1:0] COIN_FIFTY = CHG_W'(50);

    state_t           state_reg;
    logic [CHG_W-1:0] remain_reg;
    logic [CHG_W-1:0] coin_val_reg;
    logic             busy_reg;
    logic             motor_en_reg;
    logic [1:0]       motor_id_reg;
    logic             coin50_reg;
    logic             coin10_reg;
    logic             done_reg;
    logic             err_reg;

    // Change that cannot be paid in 10s is refused before anything moves.
    logic             change_ok;
    // Balance once the coin currently in flight has been acknowledged.
    logic [CHG_W-1:0] remain_after_ack;
    // Coin choice for the CHG_SEL cycle being entered. The coin outputs are
    // registered, so the choice is made on the edge that enters CHG_SEL, using
    // the balance that CHG_SEL will hold and the current tube status.
    logic             take50_from_vend;
    logic             take50_from_ack;

    assign change_ok        = (change_amt % COIN_TEN) == '0;
    assign remain_after_ack = remain_reg - coin_val_reg;
    assign take50_from_vend = (remain_reg >= COIN_FIFTY) && !hopper_empty50;
    assign take50_from_ack  = (remain_after_ack >= COIN_FIFTY) && !hopper_empty50;

    // TIMEOUT only matters up to the 8-bit counter range; nothing is built here.
    if (TIMEOUT > 255) begin : g_timeout_beyond_counter
    end

`ifdef VM_DISP_WATCHDOG_EN
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

    logic [7:0] wd_cnt_reg;
    logic       wd_expired;

    // Counts only while parked in a waiting state. Every exit from VEND or
    // COIN_WAIT lands in a non-waiting state, where the count is cleared, so
    // each wait starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg <= '0;
        end else if (state_reg == S_VEND || state_reg == S_COIN_WAIT) begin
            wd_cnt_reg <= wd_cnt_reg + 8'd1;
        end else begin
            wd_cnt_reg <= '0;
        end
    end

    assign wd_expired = (wd_cnt_reg == WD_LIMIT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            remain_reg   <= '0;
            coin_val_reg <= '0;
            busy_reg     <= 1'b0;
            motor_en_reg <= 1'b0;
            motor_id_reg <= 2'd0;
            coin50_reg   <= 1'b0;
            coin10_reg   <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            // Pulse outputs fall back to zero unless a transition raises them.
            coin50_reg <= 1'b0;
            coin10_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        busy_reg <= 1'b1;
                        if (change_ok) begin
                            motor_id_reg <= item;
                            remain_reg   <= change_amt;
                            motor_en_reg <= 1'b1;
                            state_reg    <= S_VEND;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= S_ERR;
                        end
                    end
                end

                S_VEND: begin
                    if (motor_done) begin
                        motor_en_reg <= 1'b0;
                        if (remain_reg == '0) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            if (take50_from_vend) begin
                                coin50_reg   <= 1'b1;
                                coin_val_reg <= COIN_FIFTY;
                            end else begin
                                coin10_reg   <= 1'b1;
                                coin_val_reg <= COIN_TEN;
                            end
                            state_reg <= S_CHG_SEL;
                        end
                    end
`ifdef VM_DISP_WATCHDOG_EN
                    else if (wd_expired) begin
                        motor_en_reg <= 1'b0;
                        remain_reg   <= '0;
                        err_reg      <= 1'b1;
                        state_reg    <= S_ERR;
                    end
`endif
                end

                S_CHG_SEL: begin
                    // The coin request is already on the output this cycle.
                    state_reg <= S_COIN_WAIT;
                end

                S_COIN_WAIT: begin
                    if (hopper_ack) begin
                        remain_reg <= remain_after_ack;
                        if (remain_after_ack == '0) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            if (take50_from_ack) begin
                                coin50_reg   <= 1'b1;
                                coin_val_reg <= COIN_FIFTY;
                            end else begin
                                coin10_reg   <= 1'b1;
                                coin_val_reg <= COIN_TEN;
                            end
                            state_reg <= S_CHG_SEL;
                        end
                    end
`ifdef VM_DISP_WATCHDOG_EN
                    else if (wd_expired) begin
                        remain_reg <= '0;
                        err_reg    <= 1'b1;
                        state_reg  <= S_ERR;
                    end
`endif
                end

                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                S_ERR: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    busy_reg     <= 1'b0;
                    motor_en_reg <= 1'b0;
                    state_reg    <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign motor_en = motor_en_reg;
    assign motor_id = motor_id_reg;
    assign coin50   = coin50_reg;
    assign coin10   = coin10_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vm_dispense_ctrl
//
// Directed bench for vm_dispense_ctrl. Expected pulse events (coin50, coin10,
// done, err) are queued when a request is driven; a negedge monitor pops and
// compares each pulse the DUT produces. Level checks are made #1 after the
// active edge from the stimulus sequence.
// ---------------------------------------------------------------------------
module tb_vm_dispense_ctrl;

    localparam int CHG_W = 8;

    localparam int EV_C50  = 1;
    localparam int EV_C10  = 2;
    localparam int EV_DONE = 3;
    localparam int EV_ERR  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic [1:0]       item;
    logic [CHG_W-1:0] change_amt;
    logic             motor_done;
    logic             hopper_ack;
    logic             hopper_empty50;
    logic             busy;
    logic             motor_en;
    logic [1:0]       motor_id;
    logic             coin50;
    logic             coin10;
    logic             done;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    vm_dispense_ctrl #(
        .CHG_W   (CHG_W),
        .TIMEOUT (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .item           (item),
        .change_amt     (change_amt),
        .motor_done     (motor_done),
        .hopper_ack     (hopper_ack),
        .hopper_empty50 (hopper_empty50),
        .busy           (busy),
        .motor_en       (motor_en),
        .motor_id       (motor_id),
        .coin50         (coin50),
        .coin10         (coin10),
        .done           (done),
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic score(input int ev, input string tag);
        int e;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL unexpected_%s: observed pulse expected none", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            assert (ev === e) else begin
                n_errors++;
                $error("FAIL order_%s: observed event %0d expected event %0d", tag, ev, e);
            end
        end
    endtask

    // Pulse monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (coin50 === 1'b1) score(EV_C50, "coin50");
            if (coin10 === 1'b1) score(EV_C10, "coin10");
            if (done === 1'b1)   score(EV_DONE, "done");
            if (err === 1'b1)    score(EV_ERR, "err");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] it, input logic [CHG_W-1:0] amt);
        item       = it;
        change_amt = amt;
        req        = 1'b1;
        tick();
        req        = 1'b0;
    endtask

    // motor_done is seen on the delay-th edge after the call.
    task automatic drop_item(input int delay);
        repeat (delay - 1) tick();
        motor_done = 1'b1;
        tick();
        motor_done = 1'b0;
    endtask

    // Acknowledge n coins, each two cycles after its request.
    task automatic pay_out(input int n, input bit empty_after_first);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (!(coin50 === 1'b1 || coin10 === 1'b1) && t < 20) begin
                tick();
                t++;
            end
            check("coin_seen", 32'(coin50 | coin10), 1);
            if (i == 0 && empty_after_first) hopper_empty50 = 1'b1;
            tick();
            tick();
            hopper_ack = 1'b1;
            tick();
            hopper_ack = 1'b0;
        end
    endtask

    task automatic finish_txn(input string name);
        check({name, "_done"}, 32'(done), 1);
        check({name, "_motor_off"}, 32'(motor_en), 0);
        tick();
        check({name, "_busy_low"}, 32'(busy), 0);
        check({name, "_done_single"}, 32'(done), 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        $display("txn %s item=%0d change=%0d complete", name, item, change_amt);
    endtask

    initial begin
        int t;
        rst            = 1'b1;
        req            = 1'b0;
        item           = 2'd0;
        change_amt     = '0;
        motor_done     = 1'b0;
        hopper_ack     = 1'b0;
        hopper_empty50 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset and idle: stray sensor/ack activity must do nothing.
        check("reset_outputs", 32'({busy, motor_en, motor_id, coin50, coin10, done, err}), 0);
        for (int i = 0; i < 10; i++) begin
            motor_done = (i % 2) == 0;
            hopper_ack = (i % 2) != 0;
            tick();
            check("idle_outputs", 32'({busy, motor_en, motor_id, coin50, coin10, done, err}), 0);
        end
        motor_done = 1'b0;
        hopper_ack = 1'b0;
        $display("txn idle reset and idle checks complete");

        // Juice, 70 change: 50 + 10 + 10.
        exp_q.push_back(EV_C50);
        exp_q.push_back(EV_C10);
        exp_q.push_back(EV_C10);
        exp_q.push_back(EV_DONE);
        do_req(2'd3, 8'd70);
        check("juice_busy", 32'(busy), 1);
        check("juice_motor_en", 32'(motor_en), 1);
        check("juice_motor_id", 32'(motor_id), 3);
        drop_item(5);
        check("juice_motor_off", 32'(motor_en), 0);
        check("juice_first_coin50", 32'(coin50), 1);
        pay_out(3, 1'b0);
        finish_txn("juice70");

        // Empty 50 tube: 60 paid as six 10s.
        hopper_empty50 = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(EV_C10);
        exp_q.push_back(EV_DONE);
        do_req(2'd1, 8'd60);
        check("tea_motor_id", 32'(motor_id), 1);
        drop_item(2);
        pay_out(6, 1'b0);
        finish_txn("tea60_empty50");
        hopper_empty50 = 1'b0;

        // Tube empties after the first coin: 110 = 50 then six 10s.
        exp_q.push_back(EV_C50);
        for (int i = 0; i < 6; i++) exp_q.push_back(EV_C10);
        exp_q.push_back(EV_DONE);
        do_req(2'd2, 8'd110);
        drop_item(3);
        pay_out(7, 1'b1);
        finish_txn("coke110_midempty");
        hopper_empty50 = 1'b0;

        // Change not a multiple of 10: immediate error, no motor.
        exp_q.push_back(EV_ERR);
        do_req(2'd0, 8'd25);
        check("bad_err", 32'(err), 1);
        check("bad_motor_en", 32'(motor_en), 0);
        check("bad_busy", 32'(busy), 1);
        tick();
        check("bad_err_single", 32'(err), 0);
        check("bad_busy_low", 32'(busy), 0);
        check("bad_motor_en_after", 32'(motor_en), 0);
        check("bad_queue_empty", exp_q.size(), 0);
        $display("txn bad_change item=0 change=25 complete");

        // Zero change, plus a second request during VEND that must be dropped.
        exp_q.push_back(EV_DONE);
        do_req(2'd1, 8'd0);
        check("zero_motor_en", 32'(motor_en), 1);
        item       = 2'd2;
        change_amt = 8'd30;
        req        = 1'b1;
        tick();
        req        = 1'b0;
        check("zero_id_kept", 32'(motor_id), 1);
        drop_item(2);
        check("zero_no_coins", 32'(coin50 | coin10), 0);
        finish_txn("zero_change");
        repeat (4) tick();
        check("zero_second_req_ignored", 32'(busy), 0);

        // Reset in the middle of a payout: no done or err afterwards.
        exp_q.push_back(EV_C50);
        do_req(2'd0, 8'd60);
        drop_item(2);
        @(negedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", 32'({busy, motor_en, motor_id, coin50, coin10, done, err}), 0);
        hopper_ack = 1'b1;
        tick();
        hopper_ack = 1'b0;
        repeat (3) tick();
        check("abort_idle", 32'(busy), 0);
        check("abort_queue_empty", exp_q.size(), 0);
        $display("txn reset_abort item=0 change=60 complete");

        // Motor never reports the drop.
`ifdef VM_DISP_WATCHDOG_EN
        exp_q.push_back(EV_ERR);
        do_req(2'd2, 8'd20);
        t = 0;
        while (err !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        check("wd_err_cycle_in_window", 32'(t >= 21 && t <= 22), 1);
        check("wd_motor_off", 32'(motor_en), 0);
        tick();
        check("wd_busy_low", 32'(busy), 0);
        check("wd_queue_empty", exp_q.size(), 0);
        $display("txn watchdog item=2 change=20 err after %0d cycles", t);
`else
        do_req(2'd2, 8'd20);
        t = 0;
        repeat (300) begin
            tick();
            t++;
        end
        check("nowd_busy_held", 32'(busy), 1);
        check("nowd_motor_held", 32'(motor_en), 1);
        check("nowd_no_err", 32'(err), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("nowd_reset_outputs", 32'({busy, motor_en, motor_id, coin50, coin10, done, err}), 0);
        $display("txn stuck_motor item=2 change=20 still busy after %0d cycles", t);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vm_dispense_ctrl.md
# vm_dispense_ctrl

Downstream dispense stage of the vending machine. It accepts one vend request from the vending core: an item code plus the change owed in dollars. It drives the selected item motor until the slot sensor confirms the drop, then pays the change through the coin hopper as 50- and 10-dollar coins, with a per-coin acknowledge handshake. It reports completion or error back to the core.

## Interface
Parameters:
- CHG_W, 8: width of change amount in dollars.
- TIMEOUT, 255: watchdog limit in cycles, used only when the watchdog is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  1  vend request, sampled only in IDLE.
- item  in  2  item code: 0 water, 1 black tea, 2 coke, 3 juice.
- change_amt  in  CHG_W  change owed in dollars, sampled with req.
- motor_done  in  1  slot sensor; high when the item has dropped.
- hopper_ack  in  1  hopper has released the last requested coin.
- hopper_empty50  in  1  50-dollar tube empty.
- busy  out  1  high in every state except IDLE.
- motor_en  out  1  item motor drive.
- motor_id  out  2  latched item code.
- coin50  out  1  one-cycle 50-dollar coin request.
- coin10  out  1  one-cycle 10-dollar coin request.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse.

## Operation
- States: IDLE, VEND, CHG_SEL, COIN_WAIT, DONE, ERR.
- IDLE, req=1:
  - If change_amt is a multiple of 10: latch item into motor_id and change_amt into remain, go to VEND.
  - Otherwise: go to ERR. No motor drive, nothing latched.
- VEND: motor_en=1.
  - motor_done=1 and remain=0: go to DONE.
  - motor_done=1 and remain≠0: go to CHG_SEL.
- CHG_SEL:
  - remain≥50 and hopper_empty50=0: coin50=1, coin value 50.
  - Else remain≥10: coin10=1, coin value 10.
  - Either way, go to COIN_WAIT.
- COIN_WAIT: on hopper_ack=1, set remain = remain − coin value.
  - If the new remain is 0, go to DONE; otherwise go to CHG_SEL.
- DONE: done=1, go to IDLE.
- ERR: err=1, go to IDLE.
- Arithmetic:
  - remain is CHG_W bits, unsigned; subtraction never underflows because of the ≥ checks.
  - The multiple-of-10 check is done combinationally on change_amt.
- Boundary cases:
  - req while busy: ignored, no queueing.
  - hopper_ack outside COIN_WAIT: ignored.
  - motor_done outside VEND: ignored.
  - hopper_empty50 is re-sampled at every CHG_SEL, so a tube emptying mid-payout falls back to 10s.
  - change_amt=0: vend only, no coin pulses.

## Timing
- Reset values: all outputs 0, state IDLE, remain 0. rst mid-operation aborts at the next edge with no done/err pulse.
- req sampled at edge N: busy=1 and motor_en=1 from edge N+1.
- motor_done sampled high at edge M: motor_en=0 from M+1, and coin request at M+1 when change is owed.
- A coin request is high for exactly one cycle, in CHG_SEL.
- hopper_ack sampled at edge K: next coin request at K+1 (CHG_SEL), or done at K+1.
- done and err are single-cycle. busy falls on the edge after the done/err cycle, so a new req can be accepted 2 cycles after the pulse edge.
- All outputs are registered, or decoded from state only, with no input-to-output combinational path.

## Configuration
- VM_DISP_WATCHDOG_EN compiles in an 8-bit watchdog counter that runs in VEND and COIN_WAIT.
  - The counter clears on every state change.
  - When it reaches TIMEOUT: motor_en drops, go to ERR (err pulse), remaining change is discarded.
- Without the macro, VEND and COIN_WAIT wait indefinitely, no counter is synthesized, and TIMEOUT is unused.

## Test plan
- Reset, then idle: all outputs 0 for 10 cycles; toggling hopper_ack and motor_done has no effect.
- req, item=3, change_amt=70, motor_done after 5 cycles, ack 2 cycles after each coin:
  - motor_id=3.
  - Coin sequence coin50, coin10, coin10.
  - Exactly one done; busy low 1 cycle after done.
- req, change_amt=60, hopper_empty50=1 throughout: six coin10 pulses, no coin50, then done.
- req, change_amt=25: err pulse 1 cycle after req, motor_en never asserted, busy low after.
- req, change_amt=0, then a second req during VEND:
  - motor drive, done, no coins.
  - The second req is ignored, with exactly one done.
- With VM_DISP_WATCHDOG_EN and TIMEOUT=20, motor_done never asserted: err at cycle 21–22 after entering VEND, motor_en low. The same stimulus without the macro leaves busy high indefinitely.
